muldiv_sequencer: RTL

Multi-cycle sequencer for the MUL, DIV and MOD instructions of the pipelined core.
- When the execute stage presents one of these ops, the block stalls the fetch/decode path and runs an iterative 32-step shift-add multiply or restoring divide.
- It then presents the result and destination register for one cycle, so the pipeline can write it back.
- A taken branch (flush) kills an operation in progress.

---
 rtl/muldiv_pkg.sv | 8 +
 rtl/muldiv_step.sv | 26 ++
 rtl/muldiv_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and default width for the mul/div sequencer
package muldiv_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on magnitudes; is_div selects, acc/a/b in, next acc/a/b out
module muldiv_step #(
  parameter int XLEN = muldiv_pkg::DEFAULT_XLEN
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] acc_n,
  output logic [XLEN-1:0] a_n,
  output logic [XLEN-1:0] b_n
);
  logic [XLEN-1:0] r_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  // divide: a holds the dividend shifting out MSB-first and collects quotient bits from the bottom
  // remainder stays below the divisor (<= 2^(XLEN-1)), so its top bit is always free to shift out
  always_comb begin
    r_sh  = {acc[XLEN-2:0], a[XLEN-1]};
    diff  = {1'b0, r_sh} - {1'b0, b};
    ge    = ~diff[XLEN];
    acc_n = is_div ? (ge ? diff[XLEN-1:0] : r_sh) : acc + (b[0] ? a : '0);
    a_n   = is_div ? {a[XLEN-2:0], ge} : a << 1;
    b_n   = is_div ? b : b >> 1;
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MUL/DIV/MOD unit; start/op/op1/op2/rd_in/flush in, stall/busy/done/result/rd_out/div_by_zero out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      rd_out,
  output logic            div_by_zero
);
  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      op_q;
  logic            sign_a, sign_b, dz, is_div_q, in_div, in_zero;
  logic [XLEN-1:0] acc, a, b, acc_n, a_n, b_n, fix_val;

  assign is_div_q = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign in_div   = (op == OP_DIV) || (op == OP_MOD);
  assign in_zero  = in_div && (op2 == '0);
  assign busy     = state != IDLE;
  assign stall    = reset && ((state == IDLE && start && !flush) || state == RUN || state == FIX);

  // on divide-by-zero a still holds |op1|, so MOD rebuilds op1 from it
  always_comb begin
    fix_val = dz ? (op_q == OP_MOD ? (sign_a ? -a : a) : '1)
            : op_q == OP_DIV ? (sign_a ^ sign_b ? -a : a)
            : op_q == OP_MOD ? (sign_a ? -acc : acc)
            : (sign_a ^ sign_b ? -acc : acc);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div(is_div_q),
    .acc(acc),
    .a(a),
    .b(b),
    .acc_n(acc_n),
    .a_n(a_n),
    .b_n(b_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      a           <= '0;
      b           <= '0;
      done        <= 1'b0;
      result      <= '0;
      rd_out      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          op_q   <= op;
          rd_out <= rd_in;
          sign_a <= op1[XLEN-1];
          sign_b <= op2[XLEN-1];
          a      <= op1[XLEN-1] ? -op1 : op1;
          b      <= op2[XLEN-1] ? -op2 : op2;
          acc    <= '0;
          cnt    <= '0;
          dz     <= in_zero;
          state  <= in_zero ? FIX : RUN;
        end
        RUN: if (flush) state <= IDLE;
        else begin
          acc <= acc_n;
          a   <= a_n;
          b   <= b_n;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: if (flush) state <= IDLE;
        else begin
          result      <= fix_val;
          div_by_zero <= dz;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
